// File: rtl/ttl_bcd_down_counter.sv
// Presettable multi-digit BCD down counter with borrow out and optional
// auto-reload at terminal count. BO is intended to drive the next stage's ENT.
module ttl_bcd_down_counter #(
  parameter int DIGITS     = 2,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                  Clk,
  input  logic                  Clear,
  input  logic                  Load_bar,
  input  logic                  ENT,
  input  logic                  ENP,
  input  logic                  Auto_reload,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  BO
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    q_r;
  logic [W-1:0]    q_dec;
  logic [DIGITS:0] borrow;
  logic            q_is_zero;

  // Ripple-borrow decrement. An abnormal digit (A..F) snaps to 9 and absorbs
  // the borrow, so one count brings it back into range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    q_dec     = q_r;
    borrow    = '0;
    borrow[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!borrow[i]) begin
        borrow[i+1] = 1'b0;
      end else if (q_r[4*i +: 4] == 4'd0) begin
        q_dec[4*i +: 4] = 4'd9;
        borrow[i+1]     = 1'b1;
      end else if (q_r[4*i +: 4] > 4'd9) begin
        q_dec[4*i +: 4] = 4'd9;
        borrow[i+1]     = 1'b0;
      end else begin
        q_dec[4*i +: 4] = q_r[4*i +: 4] - 4'd1;
        borrow[i+1]     = 1'b0;
      end
    end
  end

  assign q_is_zero = (q_r == '0);

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Clear) begin
      q_r <= '0;
    end else if (!Load_bar) begin
      q_r <= D;
    end else if (ENT && ENP) begin
      // Terminal count either wraps to all nines or reloads the preset.
      if (q_is_zero && Auto_reload) q_r <= D;
      else                          q_r <= q_dec;
    end
  end

  assign #(DELAY_RISE, DELAY_FALL) Q  = q_r;
  assign #(DELAY_RISE, DELAY_FALL) BO = ENT && q_is_zero;

endmodule
